dbus_arb: RTL
=============

Name: dbus_arb

Overview:
- Two-master arbiter sharing the single data-bus connector (address decoder/demux) between the instruction-fetch master (I) and the load/store master (D).
- Grants one master at a time and holds the grant until the transaction completes: slave response, decode fault, or timeout.
- Sits between the core's fetch/LSU ports and the connector's master port.

Parameters:
TIMEOUT_CYC, 255, cycles in BUSY without s_resp before a forced fault completion; 0 disables the timeout
RESET_PRIO_D, 1, round-robin pointer after reset; 1 = D wins first tie

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_req  in  1  I request; held until i_resp
i_addr  in  `XLEN  I address
i_w_rb  in  1  I write(1)/read(0)
i_acc  in  $clog2(`BUS_ACC_CNT)  I access size
i_wdata  in  `BUS_WIDTH  I write data
i_resp  out  1  I completion pulse
i_rdata  out  `BUS_WIDTH  I read data (= s_rdata)
i_fault  out  1  I fault, valid with i_resp
d_req, d_addr, d_w_rb, d_acc, d_wdata, d_resp, d_rdata, d_fault  same as the i_ ports, for D
s_req  out  1  request to connector
s_addr  out  `XLEN  muxed address
s_w_rb  out  1  muxed write/read
s_acc  out  $clog2(`BUS_ACC_CNT)  muxed size
s_wdata  out  `BUS_WIDTH  muxed write data
s_resp  in  1  connector response pulse
s_rdata  in  `BUS_WIDTH  connector read data
s_fault  in  1  slave fault
s_bus_fault  in  1  connector decode miss (no slave selected)
timeout_evt  out  1  one-cycle pulse on timeout
gnt_d  out  1  current/last grant owner (1 = D); debug

Behaviour:
- State machine: IDLE, BUSY_I, BUSY_D.
- Reset values: state IDLE; rr pointer = RESET_PRIO_D; timeout counter 0; gnt_d = RESET_PRIO_D; timeout_evt 0. With no requests, every req/resp/fault output is 0.
- IDLE arbitration is combinational, with zero added latency:
  - Only one req asserted: that master wins.
  - Both asserted: the master favoured by the rr pointer wins.
- The winner's signals are muxed to s_* in the same cycle and s_req = winner's req.
- Completion: s_resp or s_bus_fault in the same cycle returns it to the winner in that cycle and the state stays IDLE.
- Otherwise the state goes to BUSY_<winner>.
- On every grant the rr pointer flips to favour the loser. gnt_d updates at the grant.
- BUSY_x:
  - s_* is muxed from master x; s_req = x_req.
  - The other master is stalled: its resp stays 0.
- Completion in BUSY_x, on s_resp or s_bus_fault:
  - x_resp = 1 for that cycle.
  - x_fault = s_fault | s_bus_fault.
  - x_rdata = s_rdata.
  - Next state is IDLE. No re-grant occurs in the completion cycle; the next grant is earliest the following cycle.
- Timeout counter: cleared on entry to BUSY, increments each BUSY cycle without completion.
- When the counter reaches TIMEOUT_CYC-1 with no s_resp:
  - x_resp = 1, x_fault = 1, timeout_evt = 1.
  - s_req is forced 0 that cycle; state goes to IDLE.
- s_resp arriving in the same cycle as expiry: the real response wins, with no timeout_evt.
- Response with no grant (stray s_resp in IDLE with no req): ignored; no master resp.
- Master drops req while in BUSY (protocol violation): s_req follows it low, the state stays BUSY until s_resp or timeout, and the completion is still delivered to x.
- rst mid-transaction: all state returns to reset values next cycle. An outstanding slave response after reset is treated as stray.
- x_rdata is a broadcast of s_rdata; a master must sample it only when its resp = 1.
- Counter width is $clog2(TIMEOUT_CYC+1); there is no wrap-around while BUSY.

Decomposition:
- Shared femto package/header: add an ARB_STATE encoding (IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2) and a default timeout constant.
- Reuse `XLEN, `BUS_WIDTH, `BUS_ACC_CNT.
- One natural sub-module: dbus_arb_timer (load/enable/expire counter) so it can be reused by other bus arbiters.
- Muxing stays inline.

Test Plan:
- Single-cycle slave: d_req with d_addr=32'h10000004, s_resp the same cycle -> d_resp=1 in that cycle, d_rdata=s_rdata, state remains IDLE, no i_resp.
- Contention after reset: i_req and d_req both high, slave latency 3 -> D granted first (gnt_d=1); i_resp 0 until d_resp; I is granted the cycle after d_resp; ordering over 4 back-to-back pairs alternates D, I, D, I.
- Decode miss: i_req with i_addr=32'h50000000 and s_bus_fault=1 -> i_resp=1, i_fault=1 in the same cycle; s_req=1 for one cycle only.
- Timeout: TIMEOUT_CYC=8, slave never responds -> d_resp=d_fault=timeout_evt=1 exactly 8 cycles after the grant; s_req=0 in that cycle; then IDLE.
- Race: s_resp in the expiry cycle -> d_resp=1, d_fault=s_fault (0), timeout_evt=0.
- Reset mid-BUSY: rst in the 2nd BUSY_I cycle, then s_resp the cycle after reset -> no i_resp/d_resp, gnt_d=RESET_PRIO_D, state IDLE.

Source files
------------

// File: rtl/dbus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_arb_pkg
//  Purpose  : Shared bus widths, arbiter state encoding and timeout default
//             for the two-master data-bus arbiter.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 3
`endif

package dbus_arb_pkg;

  localparam int XLEN        = `XLEN;
  localparam int BUS_WIDTH   = `BUS_WIDTH;
  localparam int BUS_ACC_CNT = `BUS_ACC_CNT;
  localparam int ACC_W       = (BUS_ACC_CNT > 1) ? $clog2(BUS_ACC_CNT) : 1;

  // Cycles in BUSY without a slave response before a forced fault completion
  localparam int ARB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  // Counter width able to hold 0..cycles; never narrower than one bit
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dbus_arb_timer.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_arb_timer
//  Purpose  : Load/run/expire cycle counter for bus-transaction timeouts.
//             expire is raised in the CYCLES-th consecutive run cycle after
//             a load. CYCLES = 0 disables the timer entirely.
//  Revision : 1.0  initial release
// ============================================================================

module dbus_arb_timer
  import dbus_arb_pkg::*;
#(
  parameter int CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  generate
    if (CYCLES > 0) begin : g_enabled
      localparam int             CW   = cnt_width(CYCLES);
      localparam logic [CW-1:0]  LAST = CW'(CYCLES - 1);

      logic [CW-1:0] r_count;

      // Clear on load, count run cycles; holding at LAST prevents wrap
      always_ff @(posedge clk) begin
        if (rst || load) begin
          r_count <= '0;
        end else if (run && (r_count != LAST)) begin
          r_count <= r_count + 1'b1;
        end
      end

      assign expire = run && (r_count == LAST);
    end else begin : g_disabled
      wire w_unused = &{1'b0, clk, rst, load, run};
      assign expire = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/dbus_arb.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_arb
//  Purpose  : Round-robin arbiter sharing the data-bus connector between the
//             instruction-fetch master (I) and the load/store master (D).
//             Grant is held until slave response, decode fault or timeout.
//  Revision : 1.0  initial release
// ============================================================================

module dbus_arb
  import dbus_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC  = ARB_TIMEOUT_DEFAULT,
  parameter bit RESET_PRIO_D = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  // instruction-fetch master
  input  logic                 i_req,
  input  logic [XLEN-1:0]      i_addr,
  input  logic                 i_w_rb,
  input  logic [ACC_W-1:0]     i_acc,
  input  logic [BUS_WIDTH-1:0] i_wdata,
  output logic                 i_resp,
  output logic [BUS_WIDTH-1:0] i_rdata,
  output logic                 i_fault,
  // load/store master
  input  logic                 d_req,
  input  logic [XLEN-1:0]      d_addr,
  input  logic                 d_w_rb,
  input  logic [ACC_W-1:0]     d_acc,
  input  logic [BUS_WIDTH-1:0] d_wdata,
  output logic                 d_resp,
  output logic [BUS_WIDTH-1:0] d_rdata,
  output logic                 d_fault,
  // connector master port
  output logic                 s_req,
  output logic [XLEN-1:0]      s_addr,
  output logic                 s_w_rb,
  output logic [ACC_W-1:0]     s_acc,
  output logic [BUS_WIDTH-1:0] s_wdata,
  input  logic                 s_resp,
  input  logic [BUS_WIDTH-1:0] s_rdata,
  input  logic                 s_fault,
  input  logic                 s_bus_fault,
  // status
  output logic                 timeout_evt,
  output logic                 gnt_d
);

  arb_state_t r_state;
  logic       r_rr_d;      // 1 = D wins the next tie
  logic       r_gnt_d;

  logic w_idle;
  logic w_any_req;
  logic w_pick_d;
  logic w_sel_d;
  logic w_done_evt;
  logic w_timeout;
  logic w_complete;
  logic w_fault;

  assign w_idle     = (r_state == ARB_IDLE);
  assign w_any_req  = i_req | d_req;
  // IDLE winner: the sole requester, or the one the rr pointer favours on a tie
  assign w_pick_d   = d_req & (~i_req | r_rr_d);
  assign w_sel_d    = w_idle ? w_pick_d : (r_state == ARB_BUSY_D);
  assign w_done_evt = s_resp | s_bus_fault;

  // Counter is held clear while idle, so it starts from zero on BUSY entry
  dbus_arb_timer #(
    .CYCLES (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (w_idle),
    .run    (~w_idle & ~w_done_evt),
    .expire (w_timeout)
  );

  // A completion in IDLE only counts when someone is actually requesting;
  // a real response in the expiry cycle wins because the timer does not run then
  assign w_complete = w_idle ? (w_any_req & w_done_evt) : (w_done_evt | w_timeout);
  assign w_fault    = s_fault | s_bus_fault | w_timeout;

  // Selected master drives the connector; the request is withdrawn on timeout
  assign s_req   = (w_sel_d ? d_req : i_req) & ~w_timeout;
  assign s_addr  = w_sel_d ? d_addr  : i_addr;
  assign s_w_rb  = w_sel_d ? d_w_rb  : i_w_rb;
  assign s_acc   = w_sel_d ? d_acc   : i_acc;
  assign s_wdata = w_sel_d ? d_wdata : i_wdata;

  assign i_resp  = w_complete & ~w_sel_d;
  assign d_resp  = w_complete &  w_sel_d;
  assign i_fault = i_resp & w_fault;
  assign d_fault = d_resp & w_fault;
  assign i_rdata = s_rdata;
  assign d_rdata = s_rdata;

  assign timeout_evt = w_timeout;
  assign gnt_d       = r_gnt_d;

  // Grant state machine: arbitrate in IDLE, hold the owner until completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_rr_d  <= RESET_PRIO_D;
      r_gnt_d <= RESET_PRIO_D;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            r_rr_d  <= ~w_pick_d;
            r_gnt_d <= w_pick_d;
            if (!w_done_evt) begin
              r_state <= w_pick_d ? ARB_BUSY_D : ARB_BUSY_I;
            end
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (w_complete) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
